// File: rtl/keypad_pkg.sv
// Shared types and the key map for the hex keypad encoder.
package keypad_pkg;

  typedef enum logic [0:0] {
    IDLE,
    PRESSED
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_class_t;

  // code is only meaningful for SINGLE; it is forced to 0 otherwise so that
  // whole-struct comparisons treat all NONE (or all MULTI) results as equal.
  typedef struct packed {
    scan_class_t cls;
    logic [3:0]  code;
  } scan_result_t;

  // Key value at matrix position {row, col}; entry 0 is row 0 / column 0.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,   // row 3
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // Classify a full-matrix closure map (bit {row,col} set = key closed).
  function automatic scan_result_t classify(input logic [15:0] pressed);
    scan_result_t res;
    int unsigned  n;
    logic [3:0]   idx;
    n   = 0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (pressed[i]) begin
        n   = n + 1;
        idx = 4'(i);
      end
    end
    res.code = '0;
    if (n == 0) begin
      res.cls = NONE;
    end else if (n == 1) begin
      res.cls  = SINGLE;
      res.code = KEYMAP[idx];
    end else begin
      res.cls = MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_keypad_encoder_if.sv
// Keypad pins plus the encoded-key output bundle.
// key_valid is a one-cycle strobe qualifying key_code; there is no ready, so
// the consumer must take the value in the cycle key_valid is high. key_code
// stays stable until the next strobe, key_held is a level.
interface hex_keypad_encoder_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_col_scanner.sv
// Column scanner: drives one column low at a time, synchronises the rows and
// assembles a full-matrix scan result once per four columns.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   row_n,
  output logic [3:0]   col_n,
  output logic         scan_done,
  output scan_result_t scan_result
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [3:0]    cap0;
  logic [3:0]    cap1;
  logic [3:0]    cap2;
  logic          sample;
  logic [15:0]   pressed;

  // Rows are sampled on the last dwell cycle so the column has settled.
  assign sample    = (dwell == DWELL_LAST);
  assign scan_done = sample && (col_idx == 2'd3);
  assign col_n     = ~(4'b0001 << col_idx);

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Dwell counter and column index; the index advances after each sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell   <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Hold columns 0..2; column 3 is used live on the scan-done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap0 <= 4'hF;
      cap1 <= 4'hF;
      cap2 <= 4'hF;
    end else if (sample) begin
      case (col_idx)
        2'd0:    cap0 <= row_sync;
        2'd1:    cap1 <= row_sync;
        2'd2:    cap2 <= row_sync;
        default: ;
      endcase
    end
  end

  // Build the closure map indexed {row, col} from the four column samples.
  always_comb begin
    pressed = '0;
    for (int r = 0; r < 4; r++) begin
      pressed[r*4 + 0] = ~cap0[r];
      pressed[r*4 + 1] = ~cap1[r];
      pressed[r*4 + 2] = ~cap2[r];
      pressed[r*4 + 3] = ~row_sync[r];
    end
  end

  assign scan_result = classify(pressed);

endmodule

// File: rtl/hex_keypad_encoder.sv
// Hex keypad encoder top: debounces full-scan results and tracks
// press/release, emitting one strobe per accepted key press.
module hex_keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_keypad_encoder_if.master kp,
  output state_t               dbg_state
);

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

  logic         scan_done;
  scan_result_t scan_result;
  scan_result_t prev_result;
  logic [3:0]   db_cnt;
  logic [3:0]   db_cnt_next;
  logic         stable;
  state_t       state;
  state_t       state_next;
  logic         accept;

  keypad_col_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk         (clk),
    .rst         (rst),
    .row_n       (kp.row_n),
    .col_n       (kp.col_n),
    .scan_done   (scan_done),
    .scan_result (scan_result)
  );

  assign dbg_state = state;

  // Count consecutive identical scan results, reloading to 1 on any change.
  always_comb begin
    db_cnt_next = db_cnt;
    if (scan_done) begin
      if (scan_result != prev_result) begin
        db_cnt_next = 4'd1;
      end else if (db_cnt < DB_MAX) begin
        db_cnt_next = db_cnt + 4'd1;
      end
    end
  end

  assign stable = scan_done && (db_cnt_next == DB_MAX);

  // Debounce history: previous result and saturating match count.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_result <= '{cls: NONE, code: 4'h0};
      db_cnt      <= 4'd0;
    end else begin
      db_cnt <= db_cnt_next;
      if (scan_done) begin
        prev_result <= scan_result;
      end
    end
  end

  // Press/release decisions; rollover to another key needs a full release.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (stable && scan_result.cls == SINGLE) begin
          state_next = PRESSED;
          accept     = 1'b1;
        end
      end
      PRESSED: begin
        if (stable && scan_result.cls == NONE) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      kp.key_code  <= 4'h0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      state        <= state_next;
      kp.key_valid <= accept;
      kp.key_held  <= (state_next == PRESSED);
      if (accept) begin
        kp.key_code <= scan_result.code;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_encoder.sv
// Bench for hex_keypad_encoder: a keypad matrix model, a table of scan-level
// vectors, a reset-while-pressed sequence and a randomized run checked
// against a scan-history reference model.
module tb_hex_keypad_encoder;
  import keypad_pkg::*;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SCAN_CYCLES    = 4 * SCAN_DIV;

  localparam logic [15:0] K_NONE = 16'h0000;
  localparam logic [15:0] K_B    = 16'h0080;  // r1 c3
  localparam logic [15:0] K_0    = 16'h1000;  // r3 c0
  localparam logic [15:0] K_5    = 16'h0020;  // r1 c1
  localparam logic [15:0] K_9    = 16'h0400;  // r2 c2
  localparam logic [15:0] K_7    = 16'h0100;  // r2 c0
  localparam logic [15:0] K_E    = 16'h4000;  // r3 c2
  localparam logic [15:0] K_D    = 16'h8000;  // r3 c3

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  state_t      dbg_state;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hex_keypad_encoder_if kp();

  hex_keypad_encoder #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kp        (kp.master),
    .dbg_state (dbg_state)
  );

  // Keypad matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    kp.row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on whole scans: keeps the list of scan outcomes since reset and
  // calls a result stable when the last DEBOUNCE_SCANS outcomes agree.
  string      key_chars = "123A456B789C0FED";
  int         hist[$];      // -1 = no key, 16 = several keys, else position
  bit         m_pressed;
  logic [3:0] m_code;

  function automatic logic [3:0] key_value(input int pos);
    byte ch;
    ch = key_chars[pos];
    if (ch >= "A") return 4'(ch - "A" + 10);
    return 4'(ch - "0");
  endfunction

  function automatic bit model_scan(input logic [15:0] k);
    int res;
    bit stable;
    bit pulse;
    int n;
    pulse = 1'b0;
    n = $countones(k);
    if (n == 0) res = -1;
    else if (n > 1) res = 16;
    else begin
      res = 0;
      for (int i = 0; i < 16; i++) if (k[i]) res = i;
    end
    hist.push_back(res);
    stable = (hist.size() >= DEBOUNCE_SCANS);
    if (stable) begin
      for (int i = 1; i < DEBOUNCE_SCANS; i++)
        if (hist[hist.size() - 1 - i] != res) stable = 1'b0;
    end
    if (!m_pressed && stable && res >= 0 && res < 16) begin
      m_pressed = 1'b1;
      m_code    = key_value(res);
      pulse     = 1'b1;
    end else if (m_pressed && stable && res < 0) begin
      m_pressed = 1'b0;
    end
    return pulse;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_key_code",  32'(kp.key_code),  32'h0);
    check("rst_key_held",  32'(kp.key_held),  32'h0);
    check("rst_key_valid", 32'(kp.key_valid), 32'h0);
    check("rst_col_n",     32'(kp.col_n),     32'hE);
    check("rst_state",     32'(dbg_state),    32'(IDLE));
    rst = 1'b0;
    hist.delete();
    m_pressed  = 1'b0;
    m_code     = 4'h0;
    exp_q.delete();
    exp_cyc_q.delete();
    prev_valid = 1'b0;
  endtask

  // Holds key set k for one full scan starting at column-0 cycle 0 and
  // returns whether key_valid was seen right after this scan's done cycle.
  task automatic run_scan(input logic [15:0] k, output bit pulse_seen, output bit pulse_exp);
    logic [3:0] one;
    logic [3:0] exp_col;
    one  = 4'b0001;
    keys = k;
    pulse_exp = model_scan(k);
    if (pulse_exp) begin
      exp_q.push_back(m_code);
      exp_cyc_q.push_back(cyc + SCAN_CYCLES);
    end
    for (int c = 0; c < SCAN_CYCLES; c++) begin
      exp_col = ~(one << (c / SCAN_DIV));
      check("col_n", 32'(kp.col_n), 32'(exp_col));
      @(posedge clk); #1;
      if (kp.key_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_key_valid", 32'(kp.key_valid), 32'h0);
        end else begin
          check("pulse_code",  32'(kp.key_code), 32'(exp_q.pop_front()));
          check("pulse_cycle", 32'(cyc),         32'(exp_cyc_q.pop_front()));
        end
      end
      check("key_valid_width", 32'(kp.key_valid & prev_valid), 32'h0);
      prev_valid = kp.key_valid;
    end
    pulse_seen = kp.key_valid;
    check("key_code",  32'(kp.key_code),             32'(m_code));
    check("key_held",  32'(kp.key_held),             32'(m_pressed));
    check("fsm_state", 32'(dbg_state == PRESSED),    32'(m_pressed));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] keys;
    bit          pulse;
    logic [3:0]  code;
    bit          held;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit         seen;
    bit         pexp;
    logic [15:0] k;
    int         sel;
    int         a;
    int         b;
    int         reps;

    // idle
    tbl.push_back('{K_NONE, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{K_NONE, 1'b0, 4'h0, 1'b0});
    // B press and release
    tbl.push_back('{K_B,    1'b0, 4'h0, 1'b0});
    tbl.push_back('{K_B,    1'b1, 4'hB, 1'b1});
    tbl.push_back('{K_B,    1'b0, 4'hB, 1'b1});
    tbl.push_back('{K_NONE, 1'b0, 4'hB, 1'b1});
    tbl.push_back('{K_NONE, 1'b0, 4'hB, 1'b0});
    tbl.push_back('{K_NONE, 1'b0, 4'hB, 1'b0});
    // 0 bouncing, then steady
    tbl.push_back('{K_0,    1'b0, 4'hB, 1'b0});
    tbl.push_back('{K_NONE, 1'b0, 4'hB, 1'b0});
    tbl.push_back('{K_0,    1'b0, 4'hB, 1'b0});
    tbl.push_back('{K_NONE, 1'b0, 4'hB, 1'b0});
    tbl.push_back('{K_0,    1'b0, 4'hB, 1'b0});
    tbl.push_back('{K_0,    1'b1, 4'h0, 1'b1});
    tbl.push_back('{K_0,    1'b0, 4'h0, 1'b1});
    tbl.push_back('{K_NONE, 1'b0, 4'h0, 1'b1});
    tbl.push_back('{K_NONE, 1'b0, 4'h0, 1'b0});
    // 5, then 5+9, then 9, then release: no rollover
    tbl.push_back('{K_5,       1'b0, 4'h0, 1'b0});
    tbl.push_back('{K_5,       1'b1, 4'h5, 1'b1});
    tbl.push_back('{K_5 | K_9, 1'b0, 4'h5, 1'b1});
    tbl.push_back('{K_5 | K_9, 1'b0, 4'h5, 1'b1});
    tbl.push_back('{K_9,       1'b0, 4'h5, 1'b1});
    tbl.push_back('{K_9,       1'b0, 4'h5, 1'b1});
    tbl.push_back('{K_NONE,    1'b0, 4'h5, 1'b1});
    tbl.push_back('{K_NONE,    1'b0, 4'h5, 1'b0});
    // 7+E from idle: multi, ignored
    tbl.push_back('{K_7 | K_E, 1'b0, 4'h5, 1'b0});
    tbl.push_back('{K_7 | K_E, 1'b0, 4'h5, 1'b0});
    tbl.push_back('{K_7 | K_E, 1'b0, 4'h5, 1'b0});
    tbl.push_back('{K_NONE,    1'b0, 4'h5, 1'b0});
    tbl.push_back('{K_NONE,    1'b0, 4'h5, 1'b0});
    // D pressed (reset follows while held)
    tbl.push_back('{K_D,    1'b0, 4'h5, 1'b0});
    tbl.push_back('{K_D,    1'b1, 4'hD, 1'b1});
    tbl.push_back('{K_D,    1'b0, 4'hD, 1'b1});

    do_reset();
    foreach (tbl[i]) begin
      run_scan(tbl[i].keys, seen, pexp);
      check("tbl_pulse", 32'(seen),        32'(tbl[i].pulse));
      check("tbl_code",  32'(kp.key_code), 32'(tbl[i].code));
      check("tbl_held",  32'(kp.key_held), 32'(tbl[i].held));
    end

    // Reset mid-scan while D is pressed, keep D held afterwards.
    keys = K_D;
    repeat (7) begin @(posedge clk); #1; end
    check("pre_rst_held", 32'(kp.key_held), 32'h1);
    do_reset();
    run_scan(K_D, seen, pexp);
    check("post_rst_pulse1", 32'(seen),        32'h0);
    check("post_rst_code1",  32'(kp.key_code), 32'h0);
    run_scan(K_D, seen, pexp);
    check("post_rst_pulse2", 32'(seen),        32'h1);
    check("post_rst_code2",  32'(kp.key_code), 32'hD);
    check("post_rst_held2",  32'(kp.key_held), 32'h1);
    run_scan(K_NONE, seen, pexp);
    run_scan(K_NONE, seen, pexp);
    check("post_rst_release", 32'(kp.key_held), 32'h0);

    // Randomized scan-level stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        k = K_NONE;
      end else if (sel < 8) begin
        k = 16'h0001 << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        k = (16'h0001 << a) | (16'h0001 << b);
      end
      reps = $urandom_range(1, 3);
      repeat (reps) begin
        run_scan(k, seen, pexp);
        check("rand_pulse", 32'(seen), 32'(pexp));
      end
    end
    check("pending_pulses", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_keypad_encoder.md
Name: hex_keypad_encoder

Overview:
- Input-side counterpart of the switch/mux/seven-segment display path: scans a 4x4 hex matrix keypad (PmodKYPD pinout) and encodes the pressed key into a 4-bit nibble.
- The nibble plus a one-cycle press strobe feeds the existing hex display decode path in place of the switches.
- Handles column scanning, row synchronisation, debounce, multi-key rejection and press/release tracking.

Parameters:
- SCAN_DIV, 100000, clk cycles each column is driven (1 ms at 100 MHz); legal range is 4 or more.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a press or a release; legal range is 1 to 15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_n  output  4  keypad column drive, active-low, exactly one bit low at any time.
- key_code  output  4  last accepted key value (0x0-0xF), held until the next accepted press.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_held  output  1  high while the accepted key is considered pressed.

Behaviour:
Reset values:
- col_n=4'b1110 (column 0), column index 0, dwell counter 0, debounce counter 0, FSM IDLE.
- key_code=0, key_valid=0, key_held=0.
- Reset mid-scan or mid-press abandons everything and returns to these values on the next edge.

Row synchroniser:
- 2-flop synchroniser on row_n, reset to 4'b1111.

Column scan:
- Dwell counter runs 0..SCAN_DIV-1 per column.
- Synced rows are sampled on the last dwell cycle (settling margin), then the column index increments and wraps 3 to 0.
- col_n = ~(1 << index).

Scan result:
- Produced on the sample cycle of column 3 (the scan-done cycle), from all four column samples.
- Classes: NONE (all rows high), SINGLE(code) (exactly one low bit across 16 positions), MULTI (two or more low).

Key map (row r, column c):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: 0 F E D

Debounce:
- The counter tracks consecutive scans equal to the previous scan result (same class and same code).
- Any difference reloads the counter to 1; the counter saturates at DEBOUNCE_SCANS.
- Result is "stable" when the counter reaches DEBOUNCE_SCANS.

FSM (evaluated only on scan-done cycles):
- IDLE:
  - stable SINGLE(k) goes to PRESSED; key_code<=k; key_valid pulses on the following cycle.
  - stable NONE or MULTI stays in IDLE.
- PRESSED:
  - stable NONE goes to IDLE.
  - SINGLE of a different key, or MULTI (stable or not), stays in PRESSED with no new pulse. Rollover requires a full release.
- key_held = (state==PRESSED), registered.

Latency and pulse rules:
- key_valid asserts exactly 1 cycle after the scan-done cycle that completes the DEBOUNCE_SCANS-th matching scan.
- key_valid is never high for two consecutive cycles.
- key_code changes in the same cycle key_valid rises.

Boundary cases:
- A bounce inside the window restarts the count.
- A press shorter than DEBOUNCE_SCANS scans produces no output.
- DEBOUNCE_SCANS=1 accepts on the first scan containing the key.
- Counters never overflow: the dwell counter width is $clog2(SCAN_DIV), and the debounce counter saturates.

Decomposition:
- keypad_pkg:
  - state enum {IDLE, PRESSED}
  - scan class enum {NONE, SINGLE, MULTI}
  - scan_result_t struct (class, code)
  - KEYMAP constant (16 entries, 4-bit, indexed {row,col})
- Sub-module keypad_col_scanner:
  - contains the synchroniser, dwell counter, column drive and per-column row capture.
  - outputs scan_done (1-cycle) and scan_result_t.
- Top level keeps the debounce counter and FSM.

Test Plan:
Bench parameters are SCAN_DIV=4 and DEBOUNCE_SCANS=2 (16 cycles per scan). The bench keypad model drives a row low when its column is low and the key is closed.
1. Reset, no keys -> col_n cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; key_code=0; key_held=0.
2. Hold key "B" (r1,c3) -> key_valid pulses once, 1 cycle after the 2nd scan-done; key_code=0xB; key_held=1. Release -> key_held=0 after 2 NONE scans; no further pulse.
3. Key "0" bouncing (closed, open, closed per scan), then closed steadily -> no pulse until 2 consecutive closed scans; then a single pulse with key_code=0x0.
4. "5" held, then "5"+"9" pressed, then "9" alone, then release -> one pulse (0x5) only; key_held stays 1 until 2 NONE scans.
5. "7" and "E" pressed together from IDLE -> MULTI; no pulse; key_code unchanged.
6. Assert rst while "D" is PRESSED -> next cycle key_code=0, key_held=0, col_n=1110. Keeping "D" held -> a fresh pulse with key_code=0xD after 2 scans.
